// File: rtl/dac_update_scheduler.sv
// Periodic DAC refresh: every SAMPLE_DIV cycles latch signal[31:20] and push it to
// an I2C DAC as START, WRITE addr, WRITE hi, WRITE lo, STOP through a byte engine.
module dac_update_scheduler #(
  parameter logic [6:0]  DEV_ADDR   = 7'h60,
  parameter int unsigned SAMPLE_DIV = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] signal,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [1:0]  cmd_op,
  output logic [7:0]  cmd_byte,
  input  logic        cmd_done,
  input  logic        cmd_nack,
  output logic        busy,
  output logic [11:0] sample_out,
  output logic [7:0]  nack_count,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_HI, S_LO, S_STOP
  } state_e;

  localparam logic [1:0]  OP_START = 2'b00;
  localparam logic [1:0]  OP_WRITE = 2'b01;
  localparam logic [1:0]  OP_STOP  = 2'b10;
  localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

  state_e      state_q, state_d;
  logic        wait_q, wait_d;      // 0: ISSUE phase, 1: WAIT phase
  logic [15:0] div_q, div_d;
  logic        tick;
  logic [11:0] sample_q, sample_d;
  logic        nacked_q, nacked_d;
  logic [7:0]  nack_cnt_q, nack_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic unused_signal_bits;
  assign unused_signal_bits = ^signal[19:0];

  always_comb begin
    tick = enable && (div_q == DIV_LAST);
    if (!enable || tick) div_d = '0;
    else                 div_d = div_q + 16'd1;
  end

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path
    // through the branches below can leave one unassigned and infer a latch.
    state_d     = state_q;
    wait_d      = wait_q;
    sample_d    = sample_q;
    nacked_d    = nacked_q;
    nack_cnt_d  = nack_cnt_q;
    frame_cnt_d = frame_cnt_q;

    if (state_q == S_IDLE) begin
      wait_d = 1'b0;
      if (tick) begin
        sample_d = signal[31:20];
        nacked_d = 1'b0;
        state_d  = S_START;
      end
    end else if (!wait_q) begin
      if (cmd_ready) wait_d = 1'b1;
    end else if (cmd_done) begin
      wait_d = 1'b0;
      case (state_q)
        S_START: state_d = S_ADDR;
        S_ADDR:  state_d = S_HI;
        S_HI:    state_d = S_LO;
        S_LO:    state_d = S_STOP;
        S_STOP: begin
          state_d = S_IDLE;
          if (!nacked_q) frame_cnt_d = frame_cnt_q + 16'd1;
        end
        default: state_d = S_IDLE;
      endcase
      // A NACKed data byte aborts the frame straight to STOP.
      if (cmd_nack && (state_q inside {S_ADDR, S_HI, S_LO})) begin
        state_d  = S_STOP;
        nacked_d = 1'b1;
        if (nack_cnt_q != 8'hFF) nack_cnt_d = nack_cnt_q + 8'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of the order the simulator runs processes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_q      <= 1'b0;
      div_q       <= '0;
      sample_q    <= '0;
      nacked_q    <= 1'b0;
      nack_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      div_q       <= div_d;
      sample_q    <= sample_d;
      nacked_q    <= nacked_d;
      nack_cnt_q  <= nack_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Outputs decode registered state only, so reset clears them immediately.
  always_comb begin
    cmd_valid = (state_q != S_IDLE) && !wait_q;
    cmd_op    = OP_START;
    cmd_byte  = 8'h00;
    case (state_q)
      S_ADDR: begin cmd_op = OP_WRITE; cmd_byte = {DEV_ADDR, 1'b0}; end
      S_HI:   begin cmd_op = OP_WRITE; cmd_byte = {4'b0000, sample_q[11:8]}; end
      S_LO:   begin cmd_op = OP_WRITE; cmd_byte = sample_q[7:0]; end
      S_STOP: cmd_op = OP_STOP;
      default: ;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign sample_out  = sample_q;
  assign nack_count  = nack_cnt_q;
  assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Bench for dac_update_scheduler: a behavioural I2C byte-engine model logs every
// transfer; frames are compared against a sequence built from the address/sample rules.
module tb_dac_update_scheduler;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] data;
  } xfer_t;

  typedef struct {
    logic [31:0] sig;
    int          nidx;
    int          dly;
    int          exp_len;
    logic [7:0]  exp_hi;
    logic [7:0]  exp_lo;
    logic [11:0] exp_sample;
    int          exp_finc;
    int          exp_ninc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] signal;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_byte;
  logic        cmd_done;
  logic        cmd_nack;
  logic        busy;
  logic [11:0] sample_out;
  logic [7:0]  nack_count;
  logic [15:0] frame_count;

  int vectors = 0;
  int miscompares = 0;

  xfer_t log_q[$];
  xfer_t exp_q[$];

  int         done_delay = 3;
  int         nack_idx = 0;
  int         stall_idx = 0;
  int         stall_left = 0;
  int         stall_cycles = 0;
  logic [7:0] stall_byte = 8'h00;

  int model_frames = 0;
  int model_nacks = 0;

  dac_update_scheduler #(
    .DEV_ADDR  (7'h60),
    .SAMPLE_DIV(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .signal     (signal),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_byte   (cmd_byte),
    .cmd_done   (cmd_done),
    .cmd_nack   (cmd_nack),
    .busy       (busy),
    .sample_out (sample_out),
    .nack_count (nack_count),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic xfer_t mk(input logic [1:0] op, input logic [7:0] d);
    mk = {op, d};
  endfunction

  // Byte-engine model: decides cmd_ready at each falling edge, logs transfers,
  // answers each one with a cmd_done pulse done_delay cycles later.
  int   pending = 0;
  int   post_done = 0;
  int   write_idx = 0;
  logic pend_nack = 1'b0;
  logic pend_stop = 1'b0;
  logic outstanding = 1'b0;

  initial begin
    cmd_ready = 1'b1;
    cmd_done  = 1'b0;
    cmd_nack  = 1'b0;
    forever begin
      @(negedge clk);
      cmd_done = 1'b0;
      cmd_nack = 1'b0;
      if (reset) begin
        pending     = 0;
        post_done   = 0;
        outstanding = 1'b0;
        cmd_ready   = 1'b1;
      end else begin
        if (post_done == 1)      check("done_to_valid", cmd_valid, 1'b1);
        else if (post_done == 2) check("stop_done_to_idle", busy, 1'b0);
        post_done = 0;
        if (outstanding) check("valid_in_wait", cmd_valid, 1'b0);
        if (pending > 0) begin
          pending--;
          if (pending == 0) begin
            cmd_done    = 1'b1;
            cmd_nack    = pend_nack;
            outstanding = 1'b0;
            post_done   = pend_stop ? 2 : 1;
          end
        end
        if (cmd_valid && stall_left > 0 && cmd_op == OP_WRITE && write_idx == stall_idx - 1) begin
          cmd_ready = 1'b0;
          stall_left--;
          stall_cycles++;
          check("stall_op", cmd_op, OP_WRITE);
          check("stall_byte", cmd_byte, stall_byte);
        end else begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            log_q.push_back(mk(cmd_op, cmd_byte));
            if (cmd_op == OP_START)      write_idx = 0;
            else if (cmd_op == OP_WRITE) write_idx++;
            pend_nack   = (cmd_op == OP_WRITE) && (write_idx == nack_idx);
            pend_stop   = (cmd_op == OP_STOP);
            pending     = done_delay;
            outstanding = 1'b1;
          end
        end
      end
    end
  end

  task automatic wait_busy(input logic level, input int max_cyc, input string name);
    for (int i = 0; i < max_cyc && busy !== level; i++) @(negedge clk);
    check(name, busy, level);
  endtask

  task automatic run_frame(input logic [31:0] sig, input int nidx, input int dly);
    wait_busy(1'b0, 2000, "idle_before_frame");
    signal     = sig;
    nack_idx   = nidx;
    done_delay = dly;
    log_q.delete();
    wait_busy(1'b1, 64, "frame_start");
    wait_busy(1'b0, 2000, "frame_end");
  endtask

  // Reference frame: START, address byte, sample high nibble, sample low byte,
  // truncated after the NACKed write, always closed by STOP.
  task automatic build_model(input logic [11:0] s, input int nidx);
    logic [7:0] wr [3];
    wr[0] = 8'((7'h60 * 2));
    wr[1] = 8'(s / 256);
    wr[2] = 8'(s % 256);
    exp_q.delete();
    exp_q.push_back(mk(OP_START, 8'h00));
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(OP_WRITE, wr[k]));
      if (nidx == k + 1) break;
    end
    exp_q.push_back(mk(OP_STOP, 8'h00));
    if (nidx != 0) begin
      if (model_nacks < 255) model_nacks++;
    end else begin
      model_frames = (model_frames + 1) % 65536;
    end
  endtask

  task automatic compare_frame(input logic [11:0] exp_sample);
    check("xfer_count", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("xfer%0d", i), log_q[i], exp_q[i]);
    check("sample_out", sample_out, exp_sample);
    check("nack_count", nack_count, model_nacks);
    check("frame_count", frame_count, model_frames);
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl [6];
    int          cnt;
    int          hi_cycles;
    logic [31:0] sig;
    int          n;
    int          d;

    tbl[0] = '{32'hABC0_0000, 0, 3, 5, 8'h0A, 8'hBC, 12'hABC, 1, 0};
    tbl[1] = '{32'hABC0_0000, 1, 3, 3, 8'h0A, 8'hBC, 12'hABC, 0, 1};
    tbl[2] = '{32'h1234_5678, 2, 2, 4, 8'h01, 8'h23, 12'h123, 0, 1};
    tbl[3] = '{32'hFFF0_0000, 3, 1, 5, 8'h0F, 8'hFF, 12'hFFF, 0, 1};
    tbl[4] = '{32'h000F_FFFF, 0, 4, 5, 8'h00, 8'h00, 12'h000, 1, 0};
    tbl[5] = '{32'h8017_0000, 0, 2, 5, 8'h08, 8'h01, 12'h801, 1, 0};

    reset  = 1'b1;
    enable = 1'b0;
    signal = 32'h0;
    #1;
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_cmd_op", cmd_op, 2'b00);
    check("rst_cmd_byte", cmd_byte, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_sample_out", sample_out, 12'h000);
    check("rst_nack_count", nack_count, 8'h00);
    check("rst_frame_count", frame_count, 16'h0000);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    reset  = 1'b0;

    // Table-driven frames.
    for (int v = 0; v < 6; v++) begin
      run_frame(tbl[v].sig, tbl[v].nidx, tbl[v].dly);
      exp_q.delete();
      exp_q.push_back(mk(OP_START, 8'h00));
      exp_q.push_back(mk(OP_WRITE, 8'hC0));
      if (tbl[v].exp_len >= 4) exp_q.push_back(mk(OP_WRITE, tbl[v].exp_hi));
      if (tbl[v].exp_len == 5) exp_q.push_back(mk(OP_WRITE, tbl[v].exp_lo));
      exp_q.push_back(mk(OP_STOP, 8'h00));
      model_frames += tbl[v].exp_finc;
      model_nacks  += tbl[v].exp_ninc;
      compare_frame(tbl[v].exp_sample);
    end

    // Randomised frames against the reference model.
    for (int r = 0; r < 40; r++) begin
      sig = $urandom;
      n   = $urandom_range(0, 3);
      d   = $urandom_range(1, 5);
      run_frame(sig, n, d);
      build_model(sig[31:20], n);
      compare_frame(sig[31:20]);
    end

    // HI write held off for 10 cycles: command must stay stable, transfer once.
    stall_idx    = 2;
    stall_left   = 10;
    stall_byte   = 8'h0A;
    stall_cycles = 0;
    run_frame(32'hABC0_0000, 0, 3);
    build_model(12'hABC, 0);
    compare_frame(12'hABC);
    check("stall_cycles", stall_cycles, 10);
    stall_idx = 0;

    // Slow completions span several ticks: they are dropped, sample holds.
    wait_busy(1'b0, 2000, "slow_idle");
    signal     = 32'hABC0_0000;
    nack_idx   = 0;
    done_delay = 40;
    log_q.delete();
    wait_busy(1'b1, 64, "slow_start");
    signal = 32'h5550_0000;
    repeat (100) @(negedge clk);
    check("slow_sample_hold", sample_out, 12'hABC);
    wait_busy(1'b0, 2000, "slow_end");
    build_model(12'hABC, 0);
    compare_frame(12'hABC);
    run_frame(32'h5550_0000, 0, 3);
    build_model(12'h555, 0);
    compare_frame(12'h555);

    // enable dropped mid-frame: frame completes, nothing new until re-enabled.
    wait_busy(1'b0, 2000, "en_idle");
    signal     = 32'h3C50_0000;
    done_delay = 3;
    log_q.delete();
    wait_busy(1'b1, 64, "en_start");
    enable = 1'b0;
    wait_busy(1'b0, 500, "en_end");
    build_model(12'h3C5, 0);
    compare_frame(12'h3C5);
    hi_cycles = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) hi_cycles++;
    end
    check("disabled_stays_idle", hi_cycles, 0);
    log_q.delete();
    enable = 1'b1;
    cnt = 0;
    while (cnt < 64 && !cmd_valid) begin
      @(negedge clk);
      cnt++;
    end
    check("enable_to_start_cycles", cnt, 16);
    wait_busy(1'b0, 500, "en_frame_end");
    build_model(12'h3C5, 0);
    compare_frame(12'h3C5);

    // Reset during LO WAIT: immediate clear, no STOP, full period before START.
    wait_busy(1'b0, 2000, "rst_idle");
    signal     = 32'hABC0_0000;
    done_delay = 20;
    log_q.delete();
    wait_busy(1'b1, 64, "rst_start");
    cnt = 0;
    while (cnt < 500 && log_q.size() < 4) begin
      @(negedge clk);
      cnt++;
    end
    check("rst_lo_sent", log_q.size(), 4);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_cmd_valid", cmd_valid, 1'b0);
    check("midrst_cmd_op", cmd_op, 2'b00);
    check("midrst_cmd_byte", cmd_byte, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_sample_out", sample_out, 12'h000);
    check("midrst_nack_count", nack_count, 8'h00);
    check("midrst_frame_count", frame_count, 16'h0000);
    model_frames = 0;
    model_nacks  = 0;
    repeat (3) @(negedge clk);
    check("rst_no_stop", log_q.size(), 4);
    log_q.delete();
    done_delay = 3;
    reset = 1'b0;
    cnt = 0;
    while (cnt < 64 && !cmd_valid) begin
      @(negedge clk);
      cnt++;
    end
    check("reset_to_start_cycles", cnt, 16);
    wait_busy(1'b0, 500, "rst_frame_end");
    build_model(12'hABC, 0);
    compare_frame(12'hABC);

    // 256 NACKed frames: counter saturates and holds at 8'hFF.
    for (int f = 0; f < 256; f++) begin
      run_frame(32'h7770_0000, 1, 1);
      build_model(12'h777, 1);
      compare_frame(12'h777);
    end
    check("nack_saturated", nack_count, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dac_update_scheduler.md
DAC_UPDATE_SCHEDULER -- requirements
Module: dac_update_scheduler

Interface
REQ-001 Parameter DEV_ADDR, default 7'h60, is the 7-bit I2C address of the DAC.
REQ-002 Parameter SAMPLE_DIV, default 16, is the number of clk cycles between sample ticks; legal range 8..65535.
REQ-003 Port clk, input, 1: the single clock; all logic on rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port enable, input, 1: high = schedule periodic DAC updates.
REQ-006 Port signal, input, 32: generator output; DAC sample = signal[31:20].
REQ-007 Port cmd_valid, output, 1: command offered to the I2C byte engine.
REQ-008 Port cmd_ready, input, 1: engine accepts the offered command.
REQ-009 Port cmd_op, output, 2: 2'b00 START, 2'b01 WRITE, 2'b10 STOP; 2'b11 never driven.
REQ-010 Port cmd_byte, output, 8: data byte for WRITE; 8'h00 otherwise.
REQ-011 Port cmd_done, input, 1: one-cycle pulse when the accepted command has completed on the bus.
REQ-012 Port cmd_nack, input, 1: sampled only with cmd_done of a WRITE; high = slave NACK.
REQ-013 Port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-014 Port sample_out, output, 12: sample latched for the current or last frame.
REQ-015 Port nack_count, output, 8: saturating count of NACKed frames.
REQ-016 Port frame_count, output, 16: wrapping count of frames reaching STOP done.

Function
REQ-017 Divider counts 0..SAMPLE_DIV-1 while enable=1, held at 0 while enable=0; tick is asserted in the cycle the count equals SAMPLE_DIV-1.
REQ-018 Tick in IDLE: latch signal[31:20] into sample_out and enter START in the next cycle.
REQ-019 Tick while busy is dropped; the frame in flight is unaffected and no queueing occurs.
REQ-020 FSM states and sequence: IDLE -> START -> ADDR -> HI -> LO -> STOP -> IDLE.
REQ-021 Each non-IDLE state has an ISSUE phase (cmd_valid=1) and a WAIT phase (cmd_valid=0, awaiting cmd_done).
REQ-022 Command transfer occurs on a rising edge with cmd_valid=1 and cmd_ready=1; cmd_op/cmd_byte are held stable until that edge.
REQ-023 Exactly one command is outstanding at a time; cmd_valid is never asserted in WAIT.
REQ-024 cmd_done is ignored in IDLE and ISSUE phases.
REQ-025 Bytes: ADDR = {DEV_ADDR,1'b0}; HI = {4'b0000, sample_out[11:8]}; LO = sample_out[7:0].
REQ-026 cmd_done with cmd_nack=1 in ADDR, HI or LO: go to STOP ISSUE and increment nack_count (saturate at 8'hFF); frame_count is not incremented.
REQ-027 cmd_done in STOP: return to IDLE; frame_count increments (wrap 16'hFFFF -> 0) only if no NACK occurred in that frame.
REQ-028 enable deasserted mid-frame: frame runs to STOP completion, then IDLE; no new tick until enable=1 again.
REQ-029 cmd_done cycle to next cmd_valid assertion: exactly 1 clk.
REQ-030 Tick to START cmd_valid assertion: exactly 1 clk.

Reset
REQ-031 reset=1 forces immediately (asynchronously): FSM IDLE, divider 0, cmd_valid=0, cmd_op=2'b00, cmd_byte=8'h00, busy=0, sample_out=0, nack_count=0, frame_count=0.
REQ-032 reset mid-frame abandons the frame without issuing STOP; the first post-reset frame starts only after a full SAMPLE_DIV period with enable=1.

Verification
REQ-033 SAMPLE_DIV=16, enable=1, signal=32'hABC0_0000, engine always ready, cmd_done 3 clk after each transfer -> ops START, WRITE C0, WRITE 0A, WRITE BC, STOP; frame_count=1.
REQ-034 cmd_nack=1 on the ADDR WRITE -> next op STOP, no HI/LO writes, nack_count=1, frame_count unchanged.
REQ-035 cmd_ready held low 10 clk during HI ISSUE -> cmd_op=WRITE, cmd_byte=8'h0A stable all 10 clk; one transfer only.
REQ-036 cmd_done delayed 40 clk (spanning two ticks) -> ticks dropped, sample_out unchanged until the next IDLE tick.
REQ-037 reset pulsed during LO WAIT -> all outputs at reset values within the same cycle; no STOP issued; next START 16 clk after reset release.
REQ-038 256 consecutive NACKed frames -> nack_count holds 8'hFF.
